button_ctrl: RTL and testbench

Memory-mapped push-button peripheral that sits upstream of the bus bridge and drives its button read-data input. It synchronises and debounces the five board buttons, exposes their debounced levels, and latches sticky press events that software clears by writing 1s. It runs on the CPU clock, alongside the switch, timer and seven-segment peripherals.

---
 rtl/button_ctrl_pkg.sv | 26 ++
 rtl/button_ctrl_if.sv | 13 +
 rtl/button_ctrl_debounce_ch.sv | 56 +++++
 rtl/button_ctrl.sv | 74 +++++++
 tb/tb_button_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/button_ctrl_pkg.sv
// Shared definitions for the push-button peripheral: register map, default
// debounce length and the write-1-to-clear update helper.
package button_ctrl_pkg;

   localparam logic [31:0] BTN_LEVEL_OFF = 32'h0000_0000;
   localparam logic [31:0] BTN_PEND_OFF  = 32'h0000_0004;

`ifdef SIMULATION
   localparam int BTN_DEBOUNCE_DEFAULT = 4;
`else
   localparam int BTN_DEBOUNCE_DEFAULT = 1_000_000;
`endif

   typedef enum logic {
      SEL_LEVEL = 1'b0,
      SEL_PEND  = 1'b1
   } reg_sel_e;

   // Sticky bits: a new event wins over a clear landing on the same edge.
   function automatic logic [31:0] w1c_update(input logic [31:0] cur,
                                              input logic [31:0] clr,
                                              input logic [31:0] set);
      return (cur & ~clr) | set;
   endfunction

endpackage

// File: rtl/button_ctrl_if.sv
// Register-bus port of the button peripheral as seen from the bus bridge.
interface button_ctrl_if;
   logic        reg_sel;
   logic        wen;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   modport master (output reg_sel, output wen, output wdata,
                   input  rdata,   input  irq);
   modport slave  (input  reg_sel, input  wen, input  wdata,
                   output rdata,   output irq);
endinterface

// File: rtl/button_ctrl_debounce_ch.sv
// One button channel: 2-flop synchroniser, agreement-restart debounce counter,
// debounced level and a press pulse coincident with the level's rising edge.
module btn_debounce_ch #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic rstn,
   input  logic btn,
   output logic stable,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             meta_r;
   logic             sync_r;
   logic             stable_r;
   logic [CNT_W-1:0] cnt_r;
   logic             accept_s;

   // Two-stage synchroniser for the asynchronous pin.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
      end else begin
         meta_r <= btn;
         sync_r <= meta_r;
      end
   end

   // Level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stable_r <= 1'b0;
         cnt_r    <= '0;
      end else if (sync_r == stable_r) begin
         cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
         stable_r <= sync_r;
         cnt_r    <= '0;
      end else begin
         cnt_r <= cnt_r + CNT_ONE;
      end
   end

   // Pulse lines up with the edge that sets stable, so PENDING sets on that same edge.
   always_comb begin
      accept_s = (sync_r != stable_r) && (cnt_r == CNT_LAST);
      rise     = accept_s & sync_r;
      stable   = stable_r;
   end

endmodule

// File: rtl/button_ctrl.sv
// Push-button peripheral: debounced LEVEL register, sticky write-1-to-clear
// PENDING register and a registered interrupt.
module button_ctrl
   import button_ctrl_pkg::*;
#(
   parameter int NUM_BTN         = 5,
   parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
   parameter int CNT_W           = 20
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [NUM_BTN-1:0] button,
   button_ctrl_if.slave       bus
);

   logic [NUM_BTN-1:0] stable_s;
   logic [NUM_BTN-1:0] rise_s;
   logic [31:0]        level_s;
   logic [31:0]        clr_s;
   logic [31:0]        set_s;
   logic [31:0]        pend_next_s;
   logic [31:0]        pend_r;
   logic               irq_r;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_ch (
         .clk    (clk),
         .rstn   (rstn),
         .btn    (button[i]),
         .stable (stable_s[i]),
         .rise   (rise_s[i])
      );
   end

   // Zero-extend channel vectors and form the write-1-to-clear mask.
   always_comb begin
      level_s                = 32'h0000_0000;
      set_s                  = 32'h0000_0000;
      clr_s                  = 32'h0000_0000;
      level_s[NUM_BTN-1:0]   = stable_s;
      set_s[NUM_BTN-1:0]     = rise_s;
      if (bus.wen && (bus.reg_sel == SEL_PEND)) begin
         clr_s[NUM_BTN-1:0] = bus.wdata[NUM_BTN-1:0];
      end else begin
         clr_s = 32'h0000_0000;
      end
      pend_next_s = w1c_update(pend_r, clr_s, set_s);
   end

   // PENDING state and interrupt, which trails PENDING by one edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend_r <= 32'h0000_0000;
         irq_r  <= 1'b0;
      end else begin
         pend_r <= pend_next_s;
         irq_r  <= |pend_r;
      end
   end

   // Combinational read path for the bridge.
   always_comb begin
      case (bus.reg_sel)
         SEL_LEVEL: bus.rdata = level_s;
         SEL_PEND:  bus.rdata = pend_r;
         default:   bus.rdata = 32'h0000_0000;
      endcase
      bus.irq = irq_r;
   end

endmodule

// File: tb/tb_button_ctrl.sv
// Self-checking bench for button_ctrl: directed scenarios plus random stimulus
// against a sample-history reference model.
module tb_button_ctrl;

   localparam int NB = 5;
   localparam int DB = 4;

   logic          clk    = 1'b0;
   logic          rstn   = 1'b0;
   logic [NB-1:0] button = '0;

   button_ctrl_if bus ();

   button_ctrl #(
      .NUM_BTN         (NB),
      .DEBOUNCE_CYCLES (DB),
      .CNT_W           (3)
   ) dut (
      .clk    (clk),
      .rstn   (rstn),
      .button (button),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: pin samples pass two stages, a level flips once the last
   // DB synchronised samples all disagree with it.
   logic [NB-1:0] m_meta, m_sync, m_stable, m_pend;
   logic          m_irq;
   logic [NB-1:0] m_hist[$];

   logic [31:0] obs_level, obs_pend;
   logic        obs_irq;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_meta   = '0;
      m_sync   = '0;
      m_stable = '0;
      m_pend   = '0;
      m_irq    = 1'b0;
      m_hist.delete();
   endtask

   task automatic model_edge(input logic [NB-1:0] btn, input logic [NB-1:0] clr);
      logic [NB-1:0] rise;
      logic [NB-1:0] nxt;
      bit            all_diff;
      rise = '0;
      nxt  = m_stable;
      m_hist.push_back(m_sync);
      if (m_hist.size() > DB) void'(m_hist.pop_front());
      if (m_hist.size() == DB) begin
         for (int i = 0; i < NB; i++) begin
            all_diff = 1'b1;
            foreach (m_hist[k]) if (m_hist[k][i] == m_stable[i]) all_diff = 1'b0;
            if (all_diff) begin
               nxt[i]  = ~m_stable[i];
               rise[i] = nxt[i];
            end
         end
      end
      m_irq    = |m_pend;
      m_pend   = (m_pend & ~clr) | rise;
      m_stable = nxt;
      m_sync   = m_meta;
      m_meta   = btn;
   endtask

   task automatic sample(input string tag);
      bus.reg_sel = 1'b0;
      #1 obs_level = bus.rdata;
      check_eq({tag, "_lvl"}, obs_level, {27'b0, m_stable});
      bus.reg_sel = 1'b1;
      #1 obs_pend = bus.rdata;
      obs_irq = bus.irq;
      check_eq({tag, "_pend"}, obs_pend, {27'b0, m_pend});
      check_eq({tag, "_irq"}, {31'b0, obs_irq}, {31'b0, m_irq});
   endtask

   task automatic cycle(input string tag, input logic [NB-1:0] btn, input logic w,
                        input logic sel, input logic [31:0] wd);
      logic [NB-1:0] clr;
      button      = btn;
      bus.wen     = w;
      bus.reg_sel = sel;
      bus.wdata   = wd;
      clr = (w && sel) ? wd[NB-1:0] : '0;
      model_edge(btn, clr);
      @(posedge clk);
      #1;
      bus.wen   = 1'b0;
      bus.wdata = 32'h0;
      sample(tag);
   endtask

   task automatic idle(input string tag, input logic [NB-1:0] btn, input int n);
      for (int k = 0; k < n; k++) cycle(tag, btn, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [NB-1:0] cur;
      bus.reg_sel = 1'b0;
      bus.wen     = 1'b0;
      bus.wdata   = 32'h0;
      model_reset();

      // Reset with all buttons held.
      button = 5'h1F;
      repeat (3) @(posedge clk);
      #1 bus.reg_sel = 1'b0;
      #1 check_eq("rst_lvl", bus.rdata, 32'h0);
      bus.reg_sel = 1'b1;
      #1 check_eq("rst_pend", bus.rdata, 32'h0);
      check_eq("rst_irq", {31'b0, bus.irq}, 32'h0);
      @(posedge clk);
      #1 rstn = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         cycle("rst_rel", 5'h1F, 1'b0, 1'b0, 32'h0);
         if (k == 5) check_eq("rst_rel_e5", obs_level, 32'h00);
         if (k == 6) check_eq("rst_rel_e6", obs_level, 32'h1F);
      end
      idle("rel_all", 5'h00, 7);
      cycle("clr_all", 5'h00, 1'b1, 1'b1, 32'h1F);
      idle("settle", 5'h00, 2);

      // Clean press and release on button[2].
      for (int k = 1; k <= 7; k++) begin
         cycle("press2", 5'h04, 1'b0, 1'b0, 32'h0);
         if (k == 5) check_eq("press2_e5_lvl", obs_level, 32'h00);
         if (k == 6) check_eq("press2_e6_lvl", obs_level, 32'h04);
         if (k == 6) check_eq("press2_e6_pend", obs_pend, 32'h04);
         if (k == 6) check_eq("press2_e6_irq", {31'b0, obs_irq}, 32'h0);
         if (k == 7) check_eq("press2_e7_irq", {31'b0, obs_irq}, 32'h1);
      end
      for (int k = 1; k <= 6; k++) begin
         cycle("rel2", 5'h00, 1'b0, 1'b0, 32'h0);
         if (k == 5) check_eq("rel2_e5_lvl", obs_level, 32'h04);
         if (k == 6) check_eq("rel2_e6_lvl", obs_level, 32'h00);
         if (k == 6) check_eq("rel2_e6_pend", obs_pend, 32'h04);
      end

      // Glitch rejection on button[0], then an accepted 4-cycle pulse.
      cycle("clr_g", 5'h00, 1'b1, 1'b1, 32'h1F);
      idle("settle", 5'h00, 2);
      idle("glitch3", 5'h01, 3);
      idle("glitch_lo", 5'h00, 8);
      check_eq("glitch_lvl", obs_level, 32'h00);
      check_eq("glitch_pend", obs_pend, 32'h00);
      idle("pulse4", 5'h01, 4);
      idle("pulse_lo", 5'h00, 2);
      check_eq("pulse4_lvl", obs_level, 32'h01);
      idle("pulse_rel", 5'h00, 8);

      // Write-1-to-clear behaviour.
      cycle("clr_w", 5'h00, 1'b1, 1'b1, 32'h1F);
      idle("settle", 5'h00, 2);
      idle("press05", 5'h05, 6);
      idle("rel05", 5'h00, 6);
      check_eq("w1c_start", obs_pend, 32'h05);
      cycle("w_lvl", 5'h00, 1'b1, 1'b0, 32'h1F);
      check_eq("w_lvl_ignored", obs_pend, 32'h05);
      cycle("w1c_01", 5'h00, 1'b1, 1'b1, 32'h01);
      check_eq("w1c_01_pend", obs_pend, 32'h04);
      check_eq("w1c_01_irq", {31'b0, obs_irq}, 32'h1);
      cycle("w1c_04", 5'h00, 1'b1, 1'b1, 32'h04);
      check_eq("w1c_04_pend", obs_pend, 32'h00);
      check_eq("w1c_04_irq", {31'b0, obs_irq}, 32'h1);
      idle("w1c_lag", 5'h00, 1);
      check_eq("w1c_irq_drop", {31'b0, obs_irq}, 32'h0);

      // Clear of bit 1 on the very edge its press is accepted.
      for (int k = 1; k <= 6; k++) begin
         cycle("collide", 5'h02, (k == 6), 1'b1, 32'h02);
         if (k == 6) check_eq("collide_pend", obs_pend, 32'h02);
      end
      idle("rel1", 5'h00, 7);

      // Asynchronous reset while button[3] is mid-count.
      idle("cnt3", 5'h08, 4);
      #2 rstn = 1'b0;
      #1 bus.reg_sel = 1'b0;
      #1 check_eq("arst_lvl", bus.rdata, 32'h0);
      bus.reg_sel = 1'b1;
      #1 check_eq("arst_pend", bus.rdata, 32'h0);
      check_eq("arst_irq", {31'b0, bus.irq}, 32'h0);
      model_reset();
      @(posedge clk);
      #1 rstn = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         cycle("arst_rel", 5'h08, 1'b0, 1'b0, 32'h0);
         if (k == 5) check_eq("arst_e5_lvl", obs_level, 32'h00);
         if (k == 6) check_eq("arst_e6_lvl", obs_level, 32'h08);
         if (k == 6) check_eq("arst_e6_pend", obs_pend, 32'h08);
      end

      // Random buttons and bus writes.
      cur = 5'h08;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 5) == 0) cur[$urandom_range(0, NB - 1)] ^= 1'b1;
         cycle("rand", cur, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
               32'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
